// File: rtl/lcompressor_pkg.sv
// Shared Q-format constants, stage payload type and saturating magnitude helper
// for the multi-channel linear compressor.
package lcompressor_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned MAG_W    = SAMPLE_W - 1;

    typedef logic [MAG_W-1:0] env_t;

    typedef struct packed {
        logic                sign;
        logic                pass;
        logic [SAMPLE_W-1:0] data;
        env_t                mag;
    } sample_t;

    // |x| with the most-negative code clamped to the largest positive magnitude
    function automatic env_t sat_abs(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] neg;
        env_t                res;
        neg = SAMPLE_W'(0) - x;
        if (!x[SAMPLE_W-1]) begin
            res = x[MAG_W-1:0];
        end else if (neg[SAMPLE_W-1]) begin
            res = '1;
        end else begin
            res = neg[MAG_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/lcomp_env_follower.sv
// Per-channel peak envelope follower: attack/release update written back in the
// same cycle it is read, with the registered excess over threshold as output.
module lcomp_env_follower
    import lcompressor_pkg::*;
#(
    parameter int unsigned N_CH          = 2,
    parameter int unsigned CH_W          = 4,
    parameter int unsigned W_TOTAL       = SAMPLE_W,
    parameter int unsigned THRESHOLD_LIN = 32'h4000,
    parameter int unsigned ATTACK_SHIFT  = 0,
    parameter int unsigned RELEASE_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [CH_W-1:0]    in_ch,
    input  logic [W_TOTAL-2:0] in_mag,
    output logic [W_TOTAL-2:0] excess
);

    localparam int unsigned MW    = W_TOTAL - 1;
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [MW-1:0]    env_arr [N_CH];
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [MW-1:0]    env_cur;
    logic [MW-1:0]    env_nxt;
    logic [MW-1:0]    step;
    logic [MW-1:0]    exc_nxt;

    // Envelope step is never smaller than one LSB so the follower always converges
    always_comb begin
        in_range = in_valid && (32'(in_ch) < N_CH);
        idx      = IDX_W'(in_ch);
        env_cur  = in_range ? env_arr[idx] : '0;
        step     = '0;
        env_nxt  = env_cur;
        if (in_mag > env_cur) begin
            step = (in_mag - env_cur) >> ATTACK_SHIFT;
            if (step == '0) step = MW'(1);
            env_nxt = env_cur + step;
        end else if (in_mag < env_cur) begin
            step = (env_cur - in_mag) >> RELEASE_SHIFT;
            if (step == '0) step = MW'(1);
            env_nxt = env_cur - step;
        end
        exc_nxt = (env_nxt > MW'(THRESHOLD_LIN)) ? (env_nxt - MW'(THRESHOLD_LIN)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_CH); i++) env_arr[i] <= '0;
            excess <= '0;
        end else begin
            if (in_range) env_arr[idx] <= env_nxt;
            if (in_valid) excess <= exc_nxt;
        end
    end

endmodule

// File: rtl/lcompressor_env.sv
// Feed-forward multi-channel linear compressor: magnitude, envelope, ratio and
// output stages; sample width follows the package Q-format.
module lcompressor_env
    import lcompressor_pkg::*;
#(
    parameter int unsigned W_TOTAL       = SAMPLE_W,
    parameter int unsigned N_CH          = 2,
    parameter int unsigned CH_W          = 4,
    parameter int unsigned THRESHOLD_LIN = 32'h4000,
    parameter int unsigned RATIO_SHIFT   = 1,
    parameter int unsigned ATTACK_SHIFT  = 0,
    parameter int unsigned RELEASE_SHIFT = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_ce,
    input  logic [CH_W-1:0]           i_ch,
    input  logic signed [W_TOTAL-1:0] i_data,
    output logic                      o_ce,
    output logic [CH_W-1:0]           o_ch,
    output logic signed [W_TOTAL-1:0] o_data,
    output logic [W_TOTAL-2:0]        o_gr
);

    localparam int unsigned MW = W_TOTAL - 1;

    sample_t          s1_nxt, s1, s2, s3;
    logic             v1, v2, v3;
    logic [CH_W-1:0]  ch1, ch2, ch3;
    logic [MW-1:0]    excess;
    logic [MW-1:0]    red_nxt;
    logic [MW-1:0]    red3;
    logic [MW-1:0]    om;
    logic [W_TOTAL-1:0] out_nxt;

    always_comb begin
        s1_nxt.sign = i_data[W_TOTAL-1];
        s1_nxt.pass = (32'(i_ch) >= N_CH);
        s1_nxt.data = i_data;
        s1_nxt.mag  = sat_abs(i_data);
    end

    lcomp_env_follower #(
        .N_CH          (N_CH),
        .CH_W          (CH_W),
        .W_TOTAL       (W_TOTAL),
        .THRESHOLD_LIN (THRESHOLD_LIN),
        .ATTACK_SHIFT  (ATTACK_SHIFT),
        .RELEASE_SHIFT (RELEASE_SHIFT)
    ) u_env (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .in_valid (v1),
        .in_ch    (ch1),
        .in_mag   (s1.mag),
        .excess   (excess)
    );

    // Ratio and output shaping; out-of-range channels bypass both untouched
    always_comb begin
        red_nxt = s2.pass ? '0 : (excess - (excess >> RATIO_SHIFT));
        om      = (s3.mag > red3) ? (s3.mag - red3) : '0;
        if (s3.pass) begin
            out_nxt = s3.data;
        end else if (s3.sign) begin
            out_nxt = W_TOTAL'(0) - {1'b0, om};
        end else begin
            out_nxt = {1'b0, om};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            ch1    <= '0;
            ch2    <= '0;
            ch3    <= '0;
            red3   <= '0;
            o_ce   <= 1'b0;
            o_ch   <= '0;
            o_data <= '0;
            o_gr   <= '0;
        end else begin
            v1   <= i_ce;
            v2   <= v1;
            v3   <= v2;
            o_ce <= v3;
            if (i_ce) begin
                s1  <= s1_nxt;
                ch1 <= i_ch;
            end
            if (v1) begin
                s2  <= s1;
                ch2 <= ch1;
            end
            if (v2) begin
                s3   <= s2;
                ch3  <= ch2;
                red3 <= red_nxt;
            end
            if (v3) begin
                o_ch   <= ch3;
                o_data <= out_nxt;
                o_gr   <= red3;
            end
        end
    end

endmodule

// File: tb/tb_lcompressor_env.sv
// Scoreboard bench for lcompressor_env: a behavioural envelope model predicts
// each output when its input is driven.
module tb_lcompressor_env;

    localparam int unsigned W    = 16;
    localparam int unsigned NCH  = 2;
    localparam int unsigned CHW  = 4;
    localparam int unsigned THR  = 32'h4000;
    localparam int unsigned RS   = 1;
    localparam int unsigned AS   = 0;
    localparam int unsigned RLS  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ce;
    logic [CHW-1:0]       ch;
    logic signed [W-1:0]  data;
    logic                 o_ce;
    logic [CHW-1:0]       o_ch;
    logic signed [W-1:0]  o_data;
    logic [W-2:0]         o_gr;

    typedef struct {
        logic [CHW-1:0] ch;
        logic [W-1:0]   data;
        logic [W-2:0]   gr;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    res_t mon_t;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   env_m [NCH];

    always #5 clk = ~clk;

    lcompressor_env #(
        .W_TOTAL       (W),
        .N_CH          (NCH),
        .CH_W          (CHW),
        .THRESHOLD_LIN (THR),
        .RATIO_SHIFT   (RS),
        .ATTACK_SHIFT  (AS),
        .RELEASE_SHIFT (RLS)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_ce      (ce),
        .i_ch      (ch),
        .i_data    (data),
        .o_ce      (o_ce),
        .o_ch      (o_ch),
        .o_data    (o_data),
        .o_gr      (o_gr)
    );

    always @(negedge clk) begin
        if (o_ce === 1'b1) begin
            mon_t.ch   = o_ch;
            mon_t.data = o_data;
            mon_t.gr   = o_gr;
            obs_q.push_back(mon_t);
        end
    end

    function automatic res_t model(input logic [CHW-1:0] c, input logic [W-1:0] x);
        res_t r_out;
        int   mag, env, step, ex, red, om;
        r_out.ch = c;
        if (int'(c) >= int'(NCH)) begin
            r_out.data = x;
            r_out.gr   = '0;
            return r_out;
        end
        if (x[W-1]) mag = (x == 16'h8000) ? 32767 : 65536 - int'(x);
        else        mag = int'(x);
        env = env_m[c];
        if (mag > env) begin
            step = (mag - env) >> AS;
            if (step < 1) step = 1;
            env = env + step;
        end else if (mag < env) begin
            step = (env - mag) >> RLS;
            if (step < 1) step = 1;
            env = env - step;
        end
        env_m[c] = env;
        ex  = (env > int'(THR)) ? env - int'(THR) : 0;
        red = ex - (ex >> RS);
        om  = (mag > red) ? mag - red : 0;
        r_out.data = x[W-1] ? 16'(-om) : 16'(om);
        r_out.gr   = 15'(red);
        return r_out;
    endfunction

    task automatic send(input logic [CHW-1:0] c, input logic [W-1:0] x, input bit track);
        ce   = 1'b1;
        ch   = c;
        data = x;
        if (track) exp_q.push_back(model(c, x));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ce = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce    = 1'b1;
        ch    = '0;
        data  = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (o_ce !== 1'b0) begin n_fail++; $display("FAIL reset_o_ce: got %b want 0", o_ce); end
        n_cmp++;
        if (o_data !== 16'h0000) begin n_fail++; $display("FAIL reset_o_data: got %h want 0000", o_data); end
        n_cmp++;
        if (o_gr !== 15'h0000) begin n_fail++; $display("FAIL reset_o_gr: got %h want 0000", o_gr); end
        @(negedge clk);
        ce    = 1'b0;
        rst_n = 1'b1;
        idle(3);
        n_cmp++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_idle: got %0d outputs want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_attack();
        res_t g[$];
        res_t o, e;
        send(4'd0, 16'h6000, 1'b1);
        send(4'd0, 16'hA000, 1'b1);
        idle(6);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL attack_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); g.push_back(o);
            n_cmp++;
            if (o.ch !== e.ch || o.data !== e.data || o.gr !== e.gr) begin
                n_fail++;
                $display("FAIL attack_sb: got ch=%0d data=%h gr=%h want ch=%0d data=%h gr=%h", o.ch, o.data, o.gr, e.ch, e.data, e.gr);
            end
        end
        exp_q.delete(); obs_q.delete();
        if (g.size() == 2) begin
            n_cmp++;
            if (g[0].data !== 16'h5000 || g[0].gr !== 15'h1000 || g[0].ch !== 4'd0) begin
                n_fail++; $display("FAIL attack_pos: got data=%h gr=%h want 5000/1000", g[0].data, g[0].gr);
            end
            n_cmp++;
            if (g[1].data !== 16'hB000) begin n_fail++; $display("FAIL attack_neg: got %h want B000", g[1].data); end
        end
    endtask

    task automatic test_release();
        res_t g[$];
        res_t o, e;
        for (int i = 0; i < 40; i++) send(4'd0, 16'h2000, 1'b1);
        idle(6);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL release_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); g.push_back(o);
            n_cmp++;
            if (o.ch !== e.ch || o.data !== e.data || o.gr !== e.gr) begin
                n_fail++;
                $display("FAIL release_sb: got ch=%0d data=%h gr=%h want ch=%0d data=%h gr=%h", o.ch, o.data, o.gr, e.ch, e.data, e.gr);
            end
        end
        exp_q.delete(); obs_q.delete();
        if (g.size() == 40) begin
            n_cmp++;
            if (g[0].data !== 16'h1200 || g[0].gr !== 15'h0E00) begin
                n_fail++; $display("FAIL release_first: got data=%h gr=%h want 1200/0E00", g[0].data, g[0].gr);
            end
            for (int i = 1; i < 40; i++) begin
                n_cmp++;
                if (g[i].data < g[i-1].data) begin
                    n_fail++; $display("FAIL release_monotonic: step %0d got %h after %h", i, g[i].data, g[i-1].data);
                end
            end
            n_cmp++;
            if (g[39].data !== 16'h2000 || g[39].gr !== 15'h0000) begin
                n_fail++; $display("FAIL release_final: got data=%h gr=%h want 2000/0000", g[39].data, g[39].gr);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t g[$];
        res_t o, e;
        send(4'd0, 16'h6000, 1'b1);
        send(4'd1, 16'h2000, 1'b1);
        send(4'd0, 16'h6000, 1'b1);
        send(4'd0, 16'h6000, 1'b1);
        idle(6);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); g.push_back(o);
            n_cmp++;
            if (o.ch !== e.ch || o.data !== e.data || o.gr !== e.gr) begin
                n_fail++;
                $display("FAIL b2b_sb: got ch=%0d data=%h gr=%h want ch=%0d data=%h gr=%h", o.ch, o.data, o.gr, e.ch, e.data, e.gr);
            end
        end
        exp_q.delete(); obs_q.delete();
        if (g.size() == 4) begin
            n_cmp++;
            if (g[1].ch !== 4'd1 || g[1].data !== 16'h2000 || g[1].gr !== 15'h0000) begin
                n_fail++; $display("FAIL b2b_isolation: got ch=%0d data=%h gr=%h want 1/2000/0000", g[1].ch, g[1].data, g[1].gr);
            end
            n_cmp++;
            if (g[2].data !== 16'h5000 || g[3].data !== 16'h5000) begin
                n_fail++; $display("FAIL b2b_same_ch: got %h %h want 5000 5000", g[2].data, g[3].data);
            end
        end
    endtask

    task automatic test_extremes();
        res_t g[$];
        res_t o, e;
        send(4'd0, 16'h8000, 1'b1);
        send(4'd3, 16'h8000, 1'b1);
        send(4'd3, 16'h7ABC, 1'b1);
        idle(6);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL extreme_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); g.push_back(o);
            n_cmp++;
            if (o.ch !== e.ch || o.data !== e.data || o.gr !== e.gr) begin
                n_fail++;
                $display("FAIL extreme_sb: got ch=%0d data=%h gr=%h want ch=%0d data=%h gr=%h", o.ch, o.data, o.gr, e.ch, e.data, e.gr);
            end
        end
        exp_q.delete(); obs_q.delete();
        if (g.size() == 3) begin
            n_cmp++;
            if (g[0].data !== 16'hA001 || g[0].gr !== 15'h2000) begin
                n_fail++; $display("FAIL extreme_most_neg: got data=%h gr=%h want A001/2000", g[0].data, g[0].gr);
            end
            n_cmp++;
            if (g[1].ch !== 4'd3 || g[1].data !== 16'h8000 || g[2].data !== 16'h7ABC || g[2].gr !== 15'h0000) begin
                n_fail++; $display("FAIL extreme_passthru: got ch=%0d %h %h gr=%h want 3 8000 7ABC 0000", g[1].ch, g[1].data, g[2].data, g[2].gr);
            end
        end
    endtask

    task automatic test_reset_midstream();
        res_t o;
        send(4'd0, 16'h6000, 1'b0);
        send(4'd1, 16'h1234, 1'b0);
        ce = 1'b0;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NCH; i++) env_m[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        n_cmp++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL midreset_flush: got %0d outputs want 0", obs_q.size()); end
        obs_q.delete();
        send(4'd0, 16'h2000, 1'b1);
        idle(6);
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_fail++; $display("FAIL midreset_count: got %0d want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            n_cmp++;
            if (o.data !== 16'h2000 || o.gr !== 15'h0000 || o.data !== exp_q[0].data) begin
                n_fail++; $display("FAIL midreset_cleared: got data=%h gr=%h want 2000/0000", o.data, o.gr);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) env_m[i] = 0;
        test_reset();
        test_attack();
        test_release();
        test_back_to_back();
        test_extremes();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
